// File: rtl/mem_map_pkg.sv
// Shared memory map for the data-memory responder: address width, MMIO page
// placement, register offsets and the write-mask merge helper.
package mem_map_pkg;

  localparam int DM_ADDR_W       = 14;
  localparam int DM_DATA_W       = 32;
  localparam int MMIO_PAGE_WORDS = 16;
  localparam int MMIO_OFF_W      = 4;

  // First word address of the 16-word MMIO page (top of the 16K-word space).
  localparam logic [DM_ADDR_W-1:0] DM_MMIO_BASE = 14'h3FF0;

  // Register offsets inside the MMIO page; all other offsets read as zero.
  typedef enum logic [MMIO_OFF_W-1:0] {
    MMIO_MTIME_LO = 4'd0,
    MMIO_MTIME_HI = 4'd1,
    MMIO_SCRATCH  = 4'd2,
    MMIO_TOHOST   = 4'd3
  } mmio_reg_e;

  // Per-bit write merge: a bweb bit of 0 takes the new data bit, 1 keeps the old one.
  function automatic logic [DM_DATA_W-1:0] apply_bweb(
    input logic [DM_DATA_W-1:0] old_val,
    input logic [DM_DATA_W-1:0] new_val,
    input logic [DM_DATA_W-1:0] bweb
  );
    return (old_val & bweb) | (new_val & ~bweb);
  endfunction

endpackage

// File: rtl/dm_mmio.sv
// MMIO register file: 64-bit free-running MTIME counter, SCRATCH and TOHOST.
// Read data is combinational from the current register values; the caller
// registers it, so a read sees the counter value before that edge's increment.
module dm_mmio
  import mem_map_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [MMIO_OFF_W-1:0] offset,
  input  logic [31:0]           wdata,
  input  logic [31:0]           bweb,
  output logic [31:0]           rdata,
  output logic [31:0]           tohost,
  output logic                  tohost_valid
);

  logic [63:0] mtime_r;
  logic [31:0] scratch_r;
  logic [31:0] tohost_r;
  logic        tohost_valid_r;
  logic [31:0] rdata_s;

  // MTIME: a write to either half replaces that half only and suppresses the
  // increment for that edge; otherwise count up, wrapping naturally at 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_r <= 64'd0;
    end else if (wr_en && (offset == MMIO_MTIME_LO)) begin
      mtime_r <= {mtime_r[63:32], apply_bweb(mtime_r[31:0], wdata, bweb)};
    end else if (wr_en && (offset == MMIO_MTIME_HI)) begin
      mtime_r <= {apply_bweb(mtime_r[63:32], wdata, bweb), mtime_r[31:0]};
    end else begin
      mtime_r <= mtime_r + 64'd1;
    end
  end

  // SCRATCH: plain masked read/write register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch_r <= 32'd0;
    end else if (wr_en && (offset == MMIO_SCRATCH)) begin
      scratch_r <= apply_bweb(scratch_r, wdata, bweb);
    end else begin
      scratch_r <= scratch_r;
    end
  end

  // TOHOST: masked write, and a sticky valid flag only reset can clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_r       <= 32'd0;
      tohost_valid_r <= 1'b0;
    end else if (wr_en && (offset == MMIO_TOHOST)) begin
      tohost_r       <= apply_bweb(tohost_r, wdata, bweb);
      tohost_valid_r <= 1'b1;
    end else begin
      tohost_r       <= tohost_r;
      tohost_valid_r <= tohost_valid_r;
    end
  end

  // Read mux over the page; unmapped offsets return zero.
  always_comb begin
    rdata_s = 32'd0;
    case (offset)
      MMIO_MTIME_LO: rdata_s = mtime_r[31:0];
      MMIO_MTIME_HI: rdata_s = mtime_r[63:32];
      MMIO_SCRATCH:  rdata_s = scratch_r;
      MMIO_TOHOST:   rdata_s = tohost_r;
      default:       rdata_s = 32'd0;
    endcase
  end

  assign rdata        = rdata_s;
  assign tohost       = tohost_r;
  assign tohost_valid = tohost_valid_r;

endmodule

// File: rtl/dm_responder_chk.sv
// Simulation checker for the responder's request interface.
module dm_responder_chk (
  input logic clk,
  input logic rst,
  input logic dm_ceb
);

  // An unknown chip enable is decoded as "no access" by the design; flag it here.
  a_ceb_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(dm_ceb))
    else $error("dm_ceb is X/Z at a clock edge");

endmodule

// File: rtl/dm_responder.sv
// Single-port data-memory responder: SRAM array below MMIO_BASE, a 16-word
// MMIO page above it, registered read data with one cycle of latency.
module dm_responder
  import mem_map_pkg::*;
#(
  parameter int                ADDR_W    = DM_ADDR_W,
  parameter logic [ADDR_W-1:0] MMIO_BASE = DM_MMIO_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_ceb,
  input  logic              dm_w_en,
  input  logic [31:0]       dm_bweb,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_din,
  output logic [31:0]       dm_dout,
  output logic [31:0]       tohost,
  output logic              tohost_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Full-depth array; the words under the MMIO page exist but are never addressed.
  logic [31:0] mem_r [0:DEPTH-1];

  logic [ADDR_W:0]     addr_ext_s;
  logic [ADDR_W:0]     base_ext_s;
  logic                access_s;
  logic                is_mmio_s;
  logic                arr_we_s;
  logic                mmio_we_s;
  logic                rd_s;
  logic [MMIO_OFF_W-1:0] mmio_off_s;
  logic [31:0]         mmio_rdata_s;
  logic [31:0]         dout_r;

  // Address decode and access qualification. An X on dm_ceb falls into the
  // else branch and is treated as idle. Writes are blocked while rst is high
  // so an access caught by reset leaves the array untouched.
  always_comb begin
    addr_ext_s = {1'b0, dm_addr};
    base_ext_s = {1'b0, MMIO_BASE};
    mmio_off_s = MMIO_OFF_W'(dm_addr - MMIO_BASE);
    if (dm_ceb == 1'b0) begin
      access_s = 1'b1;
    end else begin
      access_s = 1'b0;
    end
    if ((addr_ext_s >= base_ext_s) &&
        (addr_ext_s < (base_ext_s + (ADDR_W+1)'(MMIO_PAGE_WORDS)))) begin
      is_mmio_s = 1'b1;
    end else begin
      is_mmio_s = 1'b0;
    end
    if (access_s && (dm_w_en == 1'b0) && !rst) begin
      arr_we_s  = !is_mmio_s;
      mmio_we_s = is_mmio_s;
    end else begin
      arr_we_s  = 1'b0;
      mmio_we_s = 1'b0;
    end
    if (access_s && (dm_w_en == 1'b1)) begin
      rd_s = 1'b1;
    end else begin
      rd_s = 1'b0;
    end
  end

  dm_mmio u_mmio (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (mmio_we_s),
    .offset       (mmio_off_s),
    .wdata        (dm_din),
    .bweb         (dm_bweb),
    .rdata        (mmio_rdata_s),
    .tohost       (tohost),
    .tohost_valid (tohost_valid)
  );

  dm_responder_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .dm_ceb (dm_ceb)
  );

  // Array write port with per-bit mask; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      mem_r[dm_addr] <= apply_bweb(mem_r[dm_addr], dm_din, dm_bweb);
    end
  end

  // Read data register: loads only on a read, holds across writes and idles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r <= 32'd0;
    end else if (rd_s) begin
      dout_r <= is_mmio_s ? mmio_rdata_s : mem_r[dm_addr];
    end else begin
      dout_r <= dout_r;
    end
  end

  assign dm_dout = dout_r;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder.
module tb_dm_responder;

  logic        clk;
  logic        rst;
  logic        dm_ceb;
  logic        dm_w_en;
  logic [31:0] dm_bweb;
  logic [13:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;
  logic [31:0] tohost;
  logic        tohost_valid;

  int total;
  int bad;

  localparam logic [13:0] BASE = 14'h3FF0;

  dm_responder #(.ADDR_W(14), .MMIO_BASE(14'h3FF0)) dut (
    .clk          (clk),
    .rst          (rst),
    .dm_ceb       (dm_ceb),
    .dm_w_en      (dm_w_en),
    .dm_bweb      (dm_bweb),
    .dm_addr      (dm_addr),
    .dm_din       (dm_din),
    .dm_dout      (dm_dout),
    .tohost       (tohost),
    .tohost_valid (tohost_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dm_ceb = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [13:0] a);
    dm_ceb = 1'b0; dm_w_en = 1'b1; dm_addr = a;
    tick();
    dm_ceb = 1'b1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    dm_ceb = 1'b0; dm_w_en = 1'b0; dm_addr = a; dm_din = d; dm_bweb = m;
    tick();
    dm_ceb = 1'b1; dm_w_en = 1'b1; dm_bweb = 32'hFFFF_FFFF;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; dm_ceb = 1'b1; dm_w_en = 1'b1;
    dm_bweb = 32'hFFFF_FFFF; dm_addr = 14'd0; dm_din = 32'd0;

    // Backdoor preloads (array is never reset).
    dut.mem_r[14'h0010] = 32'hDEAD_BEEF;
    dut.mem_r[14'h0020] = 32'hFFFF_FFFF;
    dut.mem_r[14'h0030] = 32'h0BAD_F00D;
    dut.mem_r[14'h3FF7] = 32'h5555_5555;

    // Reset values.
    idle(3);
    chk("rst_dout", dm_dout, 32'd0);
    chk("rst_tohost", tohost, 32'd0);
    chk("rst_valid", {31'd0, tohost_valid}, 32'd0);

    // Release, 10 idle edges, then MTIME reads.
    rst = 1'b0;
    idle(10);
    rd(BASE + 14'd0);
    chk("mtime_lo_10", dm_dout, 32'd10);
    rd(BASE + 14'd1);
    chk("mtime_hi_0", dm_dout, 32'd0);

    // Array read and hold across idles.
    rd(14'h0010);
    chk("rd_10", dm_dout, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("rd_10_hold", dm_dout, 32'hDEAD_BEEF);
    end

    // Masked array write, read twice.
    wr(14'h0020, 32'h0000_0000, 32'hFFFF_00FF);
    chk("wr_holds_dout", dm_dout, 32'hDEAD_BEEF);
    rd(14'h0020);
    chk("rd_20_mask", dm_dout, 32'hFFFF_00FF);
    rd(14'h0020);
    chk("rd_20_again", dm_dout, 32'hFFFF_00FF);

    // Write then immediate read-back.
    wr(14'h0040, 32'hCAFE_F00D, 32'h0000_0000);
    chk("wr40_holds_dout", dm_dout, 32'hFFFF_00FF);
    rd(14'h0040);
    chk("raw_40", dm_dout, 32'hCAFE_F00D);

    // SCRATCH full then partial write.
    wr(BASE + 14'd2, 32'h1234_5678, 32'h0000_0000);
    wr(BASE + 14'd2, 32'hFFFF_FFFF, 32'hFFFF_0000);
    rd(BASE + 14'd2);
    chk("scratch", dm_dout, 32'h1234_FFFF);

    // MTIME write edge does not increment.
    wr(BASE + 14'd0, 32'h0000_0100, 32'h0000_0000);
    rd(BASE + 14'd0);
    chk("mtime_noinc", dm_dout, 32'h0000_0100);

    // MTIME wrap.
    wr(BASE + 14'd0, 32'hFFFF_FFFF, 32'h0000_0000);
    wr(BASE + 14'd1, 32'hFFFF_FFFF, 32'h0000_0000);
    idle(2);
    rd(BASE + 14'd1);
    chk("wrap_hi", dm_dout, 32'd0);
    rd(BASE + 14'd0);
    chk("wrap_lo", dm_dout, 32'd2);

    // Unmapped MMIO offset and shadowed array word.
    rd(BASE + 14'd7);
    chk("mmio7_rd0", dm_dout, 32'd0);
    wr(BASE + 14'd7, 32'hA5A5_A5A5, 32'h0000_0000);
    rd(BASE + 14'd7);
    chk("mmio7_after_wr", dm_dout, 32'd0);
    chk("shadow_untouched", dut.mem_r[14'h3FF7], 32'h5555_5555);

    // TOHOST sticky valid.
    wr(BASE + 14'd3, 32'h0000_0001, 32'h0000_0000);
    chk("tohost_1", tohost, 32'd1);
    chk("valid_1", {31'd0, tohost_valid}, 32'd1);
    wr(BASE + 14'd3, 32'h0000_0000, 32'h0000_0000);
    chk("tohost_0", tohost, 32'd0);
    chk("valid_sticky", {31'd0, tohost_valid}, 32'd1);
    wr(BASE + 14'd3, 32'h0000_0001, 32'h0000_0000);

    // Reset during an array write aborts it and clears MMIO state.
    rd(14'h0010);
    chk("pre_rst_dout", dm_dout, 32'hDEAD_BEEF);
    dm_ceb = 1'b0; dm_w_en = 1'b0; dm_addr = 14'h0030;
    dm_din = 32'h1111_1111; dm_bweb = 32'h0000_0000;
    #2;
    rst = 1'b1;
    tick();
    chk("rst_abort_mem", dut.mem_r[14'h0030], 32'h0BAD_F00D);
    chk("rst_mid_dout", dm_dout, 32'd0);
    chk("rst_mid_tohost", tohost, 32'd0);
    chk("rst_mid_valid", {31'd0, tohost_valid}, 32'd0);

    // First access after release is honoured.
    dm_w_en = 1'b1; dm_bweb = 32'hFFFF_FFFF; dm_ceb = 1'b0; dm_addr = 14'h0030;
    rst = 1'b0;
    tick();
    chk("first_acc", dm_dout, 32'h0BAD_F00D);
    rd(BASE + 14'd2);
    chk("scratch_rst", dm_dout, 32'd0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter ADDR_W, 14, word-address width (16K words).
REQ-002 SHALL have parameter MMIO_BASE, 14'h3FF0, first word address of the 16-word MMIO page.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  async active-high reset.
REQ-004 SHALL have dm_ceb  input  1  chip enable, active-low.
REQ-005 SHALL have dm_w_en  input  1  write enable, active-low (0 = write, 1 = read).
REQ-006 SHALL have dm_bweb  input  32  per-bit write enable, active-low (0 = bit written).
REQ-007 SHALL have dm_addr  input  ADDR_W  word address.
REQ-008 SHALL have dm_din  input  32  write data.
REQ-009 SHALL have dm_dout  output  32  registered read data.
REQ-010 SHALL have tohost  output  32  last value written to the TOHOST register.
REQ-011 SHALL have tohost_valid  output  1  sticky flag, set by the first TOHOST write.

Function
REQ-012 SHALL treat a cycle as an access only when dm_ceb=0 at the rising edge; when dm_ceb=1, all state including dm_dout SHALL hold.
REQ-013 Read (dm_ceb=0, dm_w_en=1): dm_dout SHALL present mem[dm_addr] registered at that edge, so latency is 1 cycle. The value SHALL hold until the next read.
REQ-014 Write (dm_ceb=0, dm_w_en=0): for each bit i, target[i] SHALL become dm_din[i] if dm_bweb[i]=0 and otherwise keep its value. dm_dout SHALL hold its previous value.
REQ-015 Addresses below MMIO_BASE SHALL map to the SRAM array. Addresses MMIO_BASE..MMIO_BASE+15 SHALL map only to MMIO, and those array words SHALL be unreachable.
REQ-016 MMIO offset 0 MTIME_LO, offset 1 MTIME_HI: RW, 64-bit free-running counter, +1 every cycle, wraps from 2^64-1 to 0.
REQ-017 MMIO offset 2 SCRATCH: RW, 32 bits.
REQ-018 MMIO offset 3 TOHOST: RW. A write SHALL update tohost with the bweb mask and set tohost_valid=1. tohost_valid SHALL be cleared only by reset.
REQ-019 MMIO offsets 4..15 SHALL read 0, and writes to them SHALL be ignored.
REQ-020 An MTIME read SHALL return the counter value before that edge's increment.
REQ-021 An MTIME write SHALL apply the bweb mask to the selected half. That edge SHALL NOT increment the counter, and the other half SHALL be unchanged (no carry).
REQ-022 Read-after-write to the same address in back-to-back cycles SHALL return the newly written data. No bypass path is needed, because writes commit at the edge.
REQ-023 Unknown (X/Z) dm_ceb SHALL be treated as no access. The simulation model SHALL flag it with an assertion.

Reset
REQ-024 While rst=1, the following SHALL be 0: dm_dout, MTIME, SCRATCH, tohost, tohost_valid.
REQ-025 Array contents SHALL NOT be reset. The bench preloads them through a backdoor.
REQ-026 Reset asserted mid-access SHALL abort that access, with no array or MMIO write.
REQ-027 The first access SHALL be honoured on the first rising edge after rst deasserts.

Structure
REQ-028 MMIO_BASE, the register offsets (MTIME_LO=0, MTIME_HI=1, SCRATCH=2, TOHOST=3) and the address-width constants SHALL live in a shared package, mem_map_pkg.
REQ-029 The MMIO register file and counter SHALL be one sub-module, dm_mmio. dm_responder SHALL contain the array, the address decode and the dout register.

Verification
REQ-030 Preload mem[0x10]=0xDEADBEEF, then read 0x10 -> dm_dout=0xDEADBEEF one cycle later, holding through 3 following idle (ceb=1) cycles.
REQ-031 mem[0x20]=0xFFFFFFFF, then write din=0x00000000 with bweb=0xFFFF00FF, then read -> 0xFFFF00FF. A back-to-back read in the next cycle SHALL return the same value.
REQ-032 After reset release, idle 10 cycles, then read MTIME_LO -> 10 (the number of post-reset edges before the read edge). A read of MTIME_HI -> 0.
REQ-033 Write MTIME_LO=0xFFFFFFFF and MTIME_HI=0xFFFFFFFF, then wait 2 cycles -> counter wraps, and MTIME_HI reads 0.
REQ-034 Write TOHOST=0x00000001 -> tohost=1 and tohost_valid=1 after the edge. A subsequent write of 0 keeps tohost_valid=1. Reset clears both.
REQ-035 Write to MMIO_BASE+7, then read it -> 0. Assert rst during a write to 0x30 -> mem[0x30] is unchanged.
